ita_output_serializer: RTL and testbench
========================================

# ita_output_serializer

Parametrised output stage for ITA that replaces the fixed FIFO-controller/output-controller pair. It buffers post-activation result vectors of N elements in a DEPTH-entry FIFO and serialises each vector onto a narrower LANES-element valid/ready output port. It adds programmable almost-full back-pressure towards the controller, a tile-last marker, flush, a sticky overflow flag and synthesisable usage monitoring. It sits between `ita_activation` and the ITA output port.

## Interface
Parameters:
- `N`, 16, elements per input vector
- `WI`, 8, bits per element
- `LANES`, 4, elements per output beat; N % LANES == 0 (elaboration error otherwise)
- `DEPTH`, 8, FIFO depth in vectors, >= 2
- `SLACK`, 2, almost-full margin in vectors, 1 <= SLACK < DEPTH

Ports (clock and reset first):
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `flush_i`  in  1  synchronous clear of all contents and state
- `inp_valid_i`  in  1  push strobe (pipeline cannot stall)
- `inp_last_i`  in  1  vector ends a tile
- `inp_data_i`  in  N*WI  vector, element 0 in bits [WI-1:0]
- `full_o`  out  1  usage == DEPTH
- `almost_full_o`  out  1  usage >= DEPTH-SLACK
- `oup_valid_o`  out  1  beat valid
- `oup_ready_i`  in  1  downstream ready
- `oup_data_o`  out  LANES*WI  beat; '0 when `oup_valid_o` is low
- `oup_last_o`  out  1  final beat of a tile-last vector
- `usage_o`  out  $clog2(DEPTH+1)  vectors held, including the one being sent
- `max_usage_o`  out  $clog2(DEPTH+1)  peak usage since reset/flush
- `overflow_o`  out  1  sticky: a push was dropped

## Operation
- Storage: DEPTH x (N*WI+1) flop array with a `last` bit; write and read pointers wrap DEPTH-1 -> 0, DEPTH need not be a power of two.
- Push: on `inp_valid_i`, write the entry at wr_ptr and increment. If full and no vector retires in the same cycle, drop the push, leave pointers unchanged and set `overflow_o`.
- Serialiser FSM:
  - IDLE: entered when the FIFO is empty. Go to SEND when usage > 0.
  - SEND: `oup_valid_o`=1. The beat counter b runs 0..BEATS-1, with BEATS=N/LANES. `oup_data_o` = elements b*LANES .. b*LANES+LANES-1 of the head entry, lowest element in the LSBs.
  - On a handshake with b<BEATS-1: b++.
  - On a handshake with b==BEATS-1: b=0, retire the head (rd_ptr++, usage--), and return to IDLE if usage becomes 0.
- `oup_last_o` = `oup_valid_o` && b==BEATS-1 && head.last.
- Once `oup_valid_o` is high, data and last stay stable until the handshake.
- Simultaneous push and retire: usage is unchanged. A push is accepted when full if a retire happens in the same cycle.
- BEATS==1 (LANES==N): one beat per vector and the counter is unused.
- `max_usage_o` updates when usage_next > max.
- Flush has priority over push and pop in the same cycle. It clears pointers, usage, b, max and overflow, and sends the FSM to IDLE.

## Timing
- Reset values: all outputs 0, FSM IDLE, pointers 0, b 0.
- Push at edge t: `usage_o`, `full_o` and `almost_full_o` reflect it from t+1; `oup_valid_o` is high from t+1 at the earliest. Write-to-output latency is 1 cycle.
- Throughput: 1 beat/cycle under continuous ready. A vector takes BEATS cycles, so steady state accepts 1 vector per BEATS cycles.
- All outputs come from registers or registered state through a mux only; there is no combinational path from `inp_*` to `oup_*`.
- `oup_ready_i` -> retire is combinational into the next-state logic only.
- Reset asserted mid-burst: all state clears immediately and asynchronously. The partially sent vector is lost.
- Flush at edge t: `oup_valid_o`=0 and usage=0 from t+1.

## Test plan
Default parameters unless stated otherwise.
- **Single vector:** push one vector with elements 0..15, last=1, and hold ready=1. Expect 4 beats on cycles t+1..t+4 carrying {3,2,1,0}..{15,14,13,12}, `oup_last_o` only on beat 4, usage back to 0 at t+5.
- **Back-pressure:** toggle ready every other cycle. Data is held stable while valid && !ready, and no beat is duplicated or lost across 3 vectors.
- **Fill:** push 8 vectors with ready=0. `almost_full_o` rises after the 6th push and `full_o` after the 8th. A 9th push sets `overflow_o` and leaves usage at 8. Draining then returns the first 8 vectors intact.
- **Full with retire:** when full, push in the same cycle as the final-beat handshake. The push is accepted, usage stays 8 and `overflow_o` stays 0.
- **Wrap-around:** stream 20 vectors interleaved with random ready. Output order equals input order, and `max_usage_o` equals the reference-model peak.
- **Flush/reset and LANES==N:** flush mid-vector (b=2), then reset mid-vector. Each gives valid=0 and usage=0 on the next cycle. With LANES=16, each vector goes out in 1 beat and `oup_last_o` follows `inp_last_i`.

Source files
------------

// File: rtl/ita_output_serializer.sv
// ITA output stage: buffers N-element result vectors in a DEPTH-entry FIFO and
// serialises each one onto a LANES-element valid/ready port with usage monitoring.
module ita_output_serializer #(
  parameter int unsigned N     = 16,
  parameter int unsigned WI    = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SLACK = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         inp_valid_i,
  input  logic                         inp_last_i,
  input  logic [N*WI-1:0]              inp_data_i,
  output logic                         full_o,
  output logic                         almost_full_o,
  output logic                         oup_valid_o,
  input  logic                         oup_ready_i,
  output logic [LANES*WI-1:0]          oup_data_o,
  output logic                         oup_last_o,
  output logic [$clog2(DEPTH+1)-1:0]   usage_o,
  output logic [$clog2(DEPTH+1)-1:0]   max_usage_o,
  output logic                         overflow_o
);

  localparam int unsigned BEATS = N / LANES;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned UW    = $clog2(DEPTH + 1);
  localparam int unsigned EW    = N * WI + 1;

  if (N % LANES != 0) begin : g_bad_lanes
    $error("ita_output_serializer: N must be a multiple of LANES");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("ita_output_serializer: DEPTH must be at least 2");
  end
  if (SLACK < 1 || SLACK >= DEPTH) begin : g_bad_slack
    $error("ita_output_serializer: SLACK must satisfy 1 <= SLACK < DEPTH");
  end

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [UW-1:0]   usage_q, usage_d;
  logic [UW-1:0]   max_q, max_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            ovf_q, ovf_d;

  logic            send, last_beat, handshake, retire, full, push_ok;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [EW-1:0]   head;
  logic [LANES*WI-1:0] beat_data;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    beat_d   = beat_q;
    max_d    = max_q;
    ovf_d    = ovf_q;

    send      = (state_q == SEND);
    last_beat = (beat_q == BW'(BEATS - 1));
    handshake = send && oup_ready_i;
    retire    = handshake && last_beat;
    full      = (usage_q == UW'(DEPTH));
    // A full FIFO still accepts when the head retires on the same edge.
    push_ok   = inp_valid_i && (!full || retire);

    if (handshake) beat_d = last_beat ? '0 : beat_q + BW'(1);
    if (push_ok)   wr_ptr_d = next_ptr(wr_ptr_q);
    if (retire)    rd_ptr_d = next_ptr(rd_ptr_q);
    if (inp_valid_i && !push_ok) ovf_d = 1'b1;

    usage_d = usage_q + UW'(push_ok) - UW'(retire);
    if (usage_d > max_q) max_d = usage_d;

    unique case (state_q)
      IDLE:    if (usage_d != '0) state_d = SEND;
      SEND:    if (usage_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usage_d  = '0;
      beat_d   = '0;
      max_d    = '0;
      ovf_d    = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
      max_q    <= '0;
      beat_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usage_q  <= usage_d;
      max_q    <= max_d;
      beat_q   <= beat_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: payload storage is not reset; an entry is only read after being written
  // and the output is forced to zero while nothing is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= {inp_last_i, inp_data_i};
  end

  assign head = mem_q[rd_ptr_q];

  if (BEATS == 1) begin : g_one_beat
    assign beat_data = head[LANES*WI-1:0];
  end else begin : g_multi_beat
    logic [BEATS-1:0][LANES*WI-1:0] beats;
    assign beats     = head[N*WI-1:0];
    assign beat_data = beats[beat_q];
  end

  assign oup_valid_o   = send;
  assign oup_data_o    = send ? beat_data : '0;
  assign oup_last_o    = send && last_beat && head[EW-1];
  assign full_o        = full;
  assign almost_full_o = (usage_q >= UW'(DEPTH - SLACK));
  assign usage_o       = usage_q;
  assign max_usage_o   = max_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_ita_output_serializer.sv
// Randomised scoreboard bench for ita_output_serializer: a vector-level FIFO
// model predicts beats and status; a separate monitor compares every handshake.
module tb_ita_output_serializer;

  localparam int N     = 16;
  localparam int WI    = 8;
  localparam int LANES = 4;
  localparam int DEPTH = 8;
  localparam int SLACK = 2;
  localparam int BEATS = N / LANES;
  localparam int UW    = $clog2(DEPTH + 1);

  typedef struct {
    logic [LANES*WI-1:0] data;
    logic                last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (LANES=4)
  logic                flush = 1'b0, in_valid = 1'b0, in_last = 1'b0, ready = 1'b0;
  logic [N*WI-1:0]     in_data = '0;
  logic                full, almost_full, valid, last, overflow;
  logic [LANES*WI-1:0] data;
  logic [UW-1:0]       usage, max_usage;

  ita_output_serializer #(.N(N), .WI(WI), .LANES(LANES), .DEPTH(DEPTH), .SLACK(SLACK)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .inp_valid_i(in_valid), .inp_last_i(in_last), .inp_data_i(in_data),
    .full_o(full), .almost_full_o(almost_full),
    .oup_valid_o(valid), .oup_ready_i(ready), .oup_data_o(data), .oup_last_o(last),
    .usage_o(usage), .max_usage_o(max_usage), .overflow_o(overflow)
  );

  // Second DUT with LANES == N
  logic              b_valid_i = 1'b0, b_last_i = 1'b0;
  logic [N*WI-1:0]   b_data_i = '0;
  logic              b_full, b_afull, b_valid, b_last, b_ovf;
  logic [N*WI-1:0]   b_data;
  logic [UW-1:0]     b_usage, b_max;

  ita_output_serializer #(.N(N), .WI(WI), .LANES(N), .DEPTH(DEPTH), .SLACK(SLACK)) u_dut_wide (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0),
    .inp_valid_i(b_valid_i), .inp_last_i(b_last_i), .inp_data_i(b_data_i),
    .full_o(b_full), .almost_full_o(b_afull),
    .oup_valid_o(b_valid), .oup_ready_i(1'b1), .oup_data_o(b_data), .oup_last_o(b_last),
    .usage_o(b_usage), .max_usage_o(b_max), .overflow_o(b_ovf)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [N*WI-1:0] act, input logic [N*WI-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a count of held vectors, beats already sent from the head,
  // and a queue of the beats still owed downstream.
  int    mcnt = 0, msent = 0, mpeak = 0;
  bit    movf = 1'b0;
  beat_t expq[$];

  function automatic void model_clear();
    mcnt = 0; msent = 0; mpeak = 0; movf = 1'b0;
    expq.delete();
  endfunction

  function automatic void push_expect(input logic [N*WI-1:0] v, input logic l);
    for (int k = 0; k < BEATS; k++) begin
      beat_t b;
      for (int j = 0; j < LANES; j++) b.data[j*WI +: WI] = v[(k*LANES + j)*WI +: WI];
      b.last = l && (k == BEATS - 1);
      expq.push_back(b);
    end
  endfunction

  function automatic logic [N*WI-1:0] rand_vec();
    logic [N*WI-1:0] v;
    for (int i = 0; i < N; i++) v[i*WI +: WI] = WI'($urandom);
    return v;
  endfunction

  // One clock cycle: drive at posedge+1, check status and advance the model at negedge.
  task automatic step(input bit push, input bit l, input logic [N*WI-1:0] v, input bit rdy, input bit fl);
    bit hs, ret, acc;
    in_valid = push; in_last = l; in_data = v; ready = rdy; flush = fl;
    @(negedge clk);
    check("usage",       usage,       mcnt);
    check("valid",       valid,       mcnt > 0);
    check("full",        full,        mcnt == DEPTH);
    check("almost_full", almost_full, mcnt >= DEPTH - SLACK);
    check("overflow",    overflow,    movf);
    check("max_usage",   max_usage,   mpeak);
    if (fl) begin
      model_clear();
    end else begin
      hs  = (mcnt > 0) && rdy;
      ret = hs && (msent == BEATS - 1);
      if (hs) msent = ret ? 0 : msent + 1;
      acc = push && (mcnt < DEPTH || ret);
      if (push && !acc) movf = 1'b1;
      if (acc) push_expect(v, l);
      mcnt = mcnt + int'(acc) - int'(ret);
      if (mcnt > mpeak) mpeak = mcnt;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every accepted beat, and hold-stability while stalled.
  initial begin
    bit                  stalled = 1'b0;
    logic [LANES*WI-1:0] p_data;
    logic                p_last;
    beat_t               e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("hold_valid", valid, 1'b1);
          check("hold_data",  data,  p_data);
          check("hold_last",  last,  p_last);
        end
        if (!valid) begin
          check("idle_data", {data, last}, '0);
        end else if (ready && !flush) begin
          if (expq.size() == 0) begin
            check("unexpected_beat", data, '1);
          end else begin
            e = expq.pop_front();
            check("beat_data", data, e.data);
            check("beat_last", last, e.last);
          end
        end
        stalled = valid && !ready && !flush;
        p_data  = data;
        p_last  = last;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, '0, 1, 0);
  endtask

  initial begin
    logic [N*WI-1:0] v;
    int pushed;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", valid, 1'b0);
    check("rst_usage", usage, '0);
    check("rst_flags", {full, almost_full, overflow, last}, '0);
    check("rst_max",   max_usage, '0);
    check("rst_data",  data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single vector with elements 0..15
    for (int i = 0; i < N; i++) v[i*WI +: WI] = WI'(i);
    step(1, 1, v, 1, 0);
    drain(6);

    // Back-pressure: ready toggles each cycle across 3 vectors
    for (int c = 0; c < 24; c++) step(c < 3, c == 2, rand_vec(), c[0], 0);
    drain(4);
    check("bp_drained", expq.size(), 0);

    // Fill with ready low, one extra push overflows, then drain
    for (int i = 0; i < DEPTH + 1; i++) step(1, 1'($urandom), rand_vec(), 0, 0);
    step(0, 0, '0, 0, 0);
    drain(DEPTH * BEATS + 2);
    check("fill_drained", expq.size(), 0);

    // Full with retire on the same edge as a push
    step(0, 0, '0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 1'(i), rand_vec(), 0, 0);
    for (int i = 0; i < BEATS - 1; i++) step(0, 0, '0, 1, 0);
    step(1, 1, rand_vec(), 1, 0);
    step(0, 0, '0, 0, 0);
    drain(DEPTH * BEATS + 2);

    // Wrap-around: 20 random vectors with random ready
    step(0, 0, '0, 0, 1);
    pushed = 0;
    while (pushed < 20) begin
      bit p;
      p = 1'($urandom);
      step(p, 1'($urandom), rand_vec(), 1'($urandom), 0);
      if (p) pushed++;
    end
    drain(DEPTH * BEATS + 4);
    check("wrap_drained", expq.size(), 0);

    // Flush mid-vector at beat 2
    step(1, 1, rand_vec(), 1, 0);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 1, 1);
    step(0, 0, '0, 1, 0);
    step(1, 0, rand_vec(), 1, 0);
    drain(BEATS + 2);

    // Asynchronous reset mid-vector
    step(1, 1, rand_vec(), 1, 0);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", valid, 1'b0);
    check("arst_usage", usage, '0);
    model_clear();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 1, rand_vec(), 1, 0);
    drain(BEATS + 2);
    in_valid = 1'b0;

    // LANES == N: one beat per vector, last follows the input marker
    for (int i = 0; i < 4; i++) begin
      logic l;
      v = rand_vec();
      l = 1'(i);
      b_valid_i = 1'b1; b_last_i = l; b_data_i = v;
      @(posedge clk);
      #1;
      b_valid_i = 1'b0;
      @(negedge clk);
      check("wide_valid", b_valid, 1'b1);
      check("wide_data",  b_data,  v);
      check("wide_last",  b_last,  l);
      check("wide_usage", b_usage, 1);
      @(negedge clk);
      check("wide_done",  {b_valid, b_last}, '0);
      check("wide_usage0", b_usage, '0);
      @(posedge clk);
      #1;
    end
    check("wide_ovf", b_ovf, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
